// File: rtl/pio_out_in_irq_if.sv
`default_nettype none
// ============================================================================
// Module      : pio_out_in_irq_if
// Description : Avalon-MM slave bus bundle for the output/input PIO.
// Revision    : 1.0 - initial release
// ============================================================================
interface pio_out_in_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/pio_out_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : pio_out_in_irq
// Description : Avalon-MM output PIO with set/clear, update strobe and a
//               synchronised input port. Edge capture, IRQMASK and irq are
//               built only when PIO_EDGE_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_out_in_irq #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter int                EDGE_TYPE   = 0,
    parameter int                IRQ_TYPE    = 0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pio_out_in_irq_if.slave        bus,
    output logic [DATA_W-1:0]      out_port,
    output logic                   out_strobe,
    input  wire logic [DATA_W-1:0] in_port,
    output logic                   irq
);

    localparam logic [2:0] c_ADDR_DATA     = 3'd0;
    localparam logic [2:0] c_ADDR_IRQMASK  = 3'd1;
    localparam logic [2:0] c_ADDR_EDGECAP  = 3'd2;
    localparam logic [2:0] c_ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] c_ADDR_OUTCLEAR = 3'd4;
    localparam logic [2:0] c_ADDR_OUTREAD  = 3'd5;

    logic              w_wr;
    logic [DATA_W-1:0] w_wdata;
    logic [31:0]       w_rdata;

    logic [DATA_W-1:0] data_out_d, data_out_q;
    logic              out_strobe_d, out_strobe_q;
    logic [DATA_W-1:0] sync1_d, sync1_q;
    logic [DATA_W-1:0] sync2_d, sync2_q;

    assign w_wr    = bus.chipselect && !bus.write_n;
    assign w_wdata = bus.writedata[DATA_W-1:0];

    always_comb begin
        data_out_d   = data_out_q;
        out_strobe_d = 1'b0;
        if (w_wr) begin
            case (bus.address)
                c_ADDR_DATA: begin
                    data_out_d   = w_wdata;
                    out_strobe_d = 1'b1;
                end
                c_ADDR_OUTSET: begin
                    data_out_d   = data_out_q | w_wdata;
                    out_strobe_d = 1'b1;
                end
                c_ADDR_OUTCLEAR: begin
                    data_out_d   = data_out_q & ~w_wdata;
                    out_strobe_d = 1'b1;
                end
                default: ;
            endcase
        end
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= RESET_VALUE;
            out_strobe_q <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
        end else begin
            data_out_q   <= data_out_d;
            out_strobe_q <= out_strobe_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
        end
    end

    assign out_port   = data_out_q;
    assign out_strobe = out_strobe_q;

`ifdef PIO_EDGE_IRQ_EN
    logic [DATA_W-1:0] prev_d, prev_q;
    logic [DATA_W-1:0] irqmask_d, irqmask_q;
    logic [DATA_W-1:0] edgecap_d, edgecap_q;
    logic [1:0]        prime_d, prime_q;
    logic [DATA_W-1:0] w_rise, w_fall, w_edge;

    always_comb begin
        prev_d  = sync2_q;
        prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
        w_rise  = sync2_q & ~prev_q;
        w_fall  = ~sync2_q & prev_q;
        case (EDGE_TYPE)
            0:       w_edge = w_rise;
            1:       w_edge = w_fall;
            default: w_edge = w_rise | w_fall;
        endcase

        irqmask_d = irqmask_q;
        if (w_wr && bus.address == c_ADDR_IRQMASK) begin
            irqmask_d = w_wdata;
        end

        // Clear first, then OR in new edges so a simultaneous edge wins.
        edgecap_d = edgecap_q;
        if (w_wr && bus.address == c_ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~w_wdata;
        end
        if (prime_q == 2'd3) begin
            edgecap_d = edgecap_d | w_edge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            prime_q   <= 2'd0;
        end else begin
            prev_q    <= prev_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            prime_q   <= prime_d;
        end
    end

    generate
        if (IRQ_TYPE == 0) begin : g_irq_edge
            assign irq = |(edgecap_q & irqmask_q);
        end else begin : g_irq_level
            assign irq = |(sync2_q & irqmask_q);
        end
    endgenerate
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            c_ADDR_DATA:    w_rdata[DATA_W-1:0] = sync2_q;
`ifdef PIO_EDGE_IRQ_EN
            c_ADDR_IRQMASK: w_rdata[DATA_W-1:0] = irqmask_q;
            c_ADDR_EDGECAP: w_rdata[DATA_W-1:0] = edgecap_q;
`endif
            c_ADDR_OUTREAD: w_rdata[DATA_W-1:0] = data_out_q;
            default:        w_rdata = '0;
        endcase
    end

    assign bus.readdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pio_out_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_out_in_irq
// Description : Directed self-checking bench for pio_out_in_irq
//               (RESET_VALUE = 32'hA5, rising edges, edge interrupt).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_out_in_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_port;
    logic [31:0] out_port;
    logic        out_strobe;
    logic        irq;
    int          total = 0;
    int          bad   = 0;

    pio_out_in_irq_if bus ();

    pio_out_in_irq #(
        .DATA_W      (32),
        .RESET_VALUE (32'hA5),
        .EDGE_TYPE   (0),
        .IRQ_TYPE    (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .out_port   (out_port),
        .out_strobe (out_strobe),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
    endtask

    task automatic set_write(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
    endtask

    task automatic peek(input logic [2:0] a, input string tag, input logic [31:0] exp);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        check(tag, bus.readdata, exp);
        bus_idle();
    endtask

    initial begin
        reset   = 1'b1;
        in_port = 32'h0;
        bus_idle();
        repeat (2) @(negedge clk);

        check("rst_out_port", out_port, 32'hA5);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_strobe", {31'b0, out_strobe}, 32'h0);
        peek(3'd5, "rst_outread", 32'hA5);
        reset = 1'b0;

        // DATA write, OUTSET, OUTCLEAR back to back
        set_write(3'd0, 32'h0000_00F0);
        @(negedge clk);
        check("wr_data_out", out_port, 32'hF0);
        check("wr_data_strobe", {31'b0, out_strobe}, 32'h1);
        set_write(3'd3, 32'h0F);
        @(negedge clk);
        check("outset_out", out_port, 32'hFF);
        check("outset_strobe", {31'b0, out_strobe}, 32'h1);
        set_write(3'd4, 32'h30);
        @(negedge clk);
        check("outclr_out", out_port, 32'hCF);
        check("outclr_strobe", {31'b0, out_strobe}, 32'h1);
        bus_idle();
        @(negedge clk);
        check("strobe_end", {31'b0, out_strobe}, 32'h0);
        peek(3'd5, "outread_cf", 32'hCF);
        peek(3'd3, "outset_reads0", 32'h0);

`ifdef PIO_EDGE_IRQ_EN
        set_write(3'd1, 32'h4);
        @(negedge clk);
        bus_idle();
        peek(3'd1, "irqmask_rd", 32'h4);

        in_port = 32'h4;
        repeat (2) @(negedge clk);
        check("irq_early", {31'b0, irq}, 32'h0);
        peek(3'd2, "ecap_early", 32'h0);
        @(negedge clk);
        check("irq_set", {31'b0, irq}, 32'h1);
        peek(3'd2, "ecap_set", 32'h4);
        set_write(3'd2, 32'h4);
        @(negedge clk);
        bus_idle();
        check("irq_cleared", {31'b0, irq}, 32'h0);
        peek(3'd2, "ecap_cleared", 32'h0);

        // Clear of bit 0 lands on the same edge that detects a new bit-0 rise
        in_port = 32'h5;
        repeat (2) @(negedge clk);
        set_write(3'd2, 32'h1);
        @(negedge clk);
        bus_idle();
        peek(3'd2, "set_wins", 32'h1);
        set_write(3'd2, 32'h1);
        @(negedge clk);
        bus_idle();
        in_port = 32'h4;
        repeat (4) @(negedge clk);
        peek(3'd2, "no_fall_capture", 32'h0);
`else
        set_write(3'd1, 32'hFFFF_FFFF);
        @(negedge clk);
        bus_idle();
        peek(3'd1, "irqmask_absent", 32'h0);
        in_port = 32'h4;
        repeat (4) @(negedge clk);
        peek(3'd2, "ecap_absent", 32'h0);
        check("irq_tied_low", {31'b0, irq}, 32'h0);
`endif
        peek(3'd0, "in_sync_rd", 32'h4);

        // Input held high across reset release must not look like an edge
        reset   = 1'b1;
        in_port = 32'hFF;
        repeat (2) @(negedge clk);
        check("rst2_out_port", out_port, 32'hA5);
        reset = 1'b0;
        @(negedge clk);
        peek(3'd0, "sync_1clk", 32'h0);
        @(negedge clk);
        peek(3'd0, "sync_2clk", 32'hFF);
        repeat (4) @(negedge clk);
        peek(3'd2, "prime_no_ecap", 32'h0);
        set_write(3'd1, 32'hFF);
        @(negedge clk);
        bus_idle();
        check("prime_no_irq", {31'b0, irq}, 32'h0);

        // Reset right after the accepting edge kills the pending strobe
        set_write(3'd0, 32'h12);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus_idle();
        #1;
        check("cancel_strobe", {31'b0, out_strobe}, 32'h0);
        check("cancel_out_port", out_port, 32'hA5);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("cancel_strobe_after", {31'b0, out_strobe}, 32'h0);
        check("cancel_out_after", out_port, 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
